// File: rtl/iccm_prog_pkg.sv
// Shared types and constants for the ICCM boot-time programming controller.
package iccm_prog_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } prog_state_e;

  localparam int          BytesPerWord     = 4;
  localparam logic [31:0] END_WORD_DEFAULT = 32'h0000_0FFF;

endpackage

// File: rtl/iccm_word_packer.sv
// Packs received bytes into a 32-bit little-endian word; exposes the word
// including the byte being strobed so the caller can decide on the last byte.
module iccm_word_packer
  import iccm_prog_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr,
  input  logic        strobe,
  input  logic [7:0]  rx_byte,
  output logic [1:0]  byte_cnt,
  output logic [31:0] word,
  output logic [31:0] word_next,
  output logic        last
);

  always_comb begin
    word_next = word;
    word_next[8*byte_cnt +: 8] = rx_byte;
  end

  assign last = strobe && (byte_cnt == 2'(BytesPerWord - 1));

  // byte_cnt is two bits wide, so the 4th byte wraps it back to 0.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr) begin
      byte_cnt <= 2'd0;
      word     <= '0;
    end else if (strobe) begin
      byte_cnt <= byte_cnt + 2'd1;
      word     <= word_next;
    end
  end

endmodule

// File: rtl/iccm_prog_ctrl.sv
// ICCM programming controller: UART bytes -> sequential ICCM word writes, then
// the memory port is handed to the fetch adapter and the core is released.
module iccm_prog_ctrl
  import iccm_prog_pkg::*;
#(
  parameter int          AddrW         = 12,
  parameter int          DataW         = 32,
  parameter int          MaxWords      = 4096,
  parameter logic [31:0] EndWord       = END_WORD_DEFAULT,
  parameter int          TimeoutCycles = 1_000_000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             prog_en_i,
  input  logic             rx_dv_i,
  input  logic [7:0]       rx_byte_i,
  input  logic             fetch_req_i,
  input  logic [AddrW-1:0] fetch_addr_i,
  output logic             fetch_gnt_o,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [AddrW-1:0] mem_addr_o,
  output logic [DataW-1:0] mem_wdata_o,
  output logic [3:0]       mem_wmask_o,
  output logic             core_rst_hold_o,
  output logic             done_o,
  output logic             err_o,
  output logic [AddrW:0]   word_cnt_o,
  output logic [1:0]       state_o
);

  localparam logic [1:0] ST_IDLE    = IDLE;
  localparam logic [1:0] ST_COLLECT = COLLECT;
  localparam logic [1:0] ST_WRITE   = WRITE;
  localparam logic [1:0] ST_DONE    = DONE;

  localparam int             IdleW    = $clog2(TimeoutCycles + 1);
  localparam logic [AddrW:0] MaxCnt   = (AddrW + 1)'(MaxWords);
  localparam logic [IdleW-1:0] IdleLim = IdleW'(TimeoutCycles - 1);

  logic [1:0]       state, state_next;
  logic [IdleW-1:0] idle_cnt;
  logic             set_err;
  logic             packer_strobe, idle_tick, timeout, last;
  logic [1:0]       byte_cnt;
  logic [31:0]      word, word_next;

  // Bytes are accepted in WRITE too, so a back-to-back stream never loses one.
  assign packer_strobe = rx_dv_i && ((state == ST_COLLECT) || (state == ST_WRITE));
  assign idle_tick     = (state == ST_COLLECT) && (byte_cnt != 2'd0) && !rx_dv_i;
  assign timeout       = idle_tick && (idle_cnt == IdleLim);

  iccm_word_packer u_packer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr       (timeout),
    .strobe    (packer_strobe),
    .rx_byte   (rx_byte_i),
    .byte_cnt  (byte_cnt),
    .word      (word),
    .word_next (word_next),
    .last      (last)
  );

  always_comb begin
    state_next = state;
    set_err    = 1'b0;
    case (state)
      ST_IDLE:    state_next = prog_en_i ? ST_COLLECT : ST_DONE;
      ST_COLLECT: begin
        if (last) begin
          if (word_next == EndWord) begin
            state_next = ST_DONE;
          end else if (word_cnt_o == MaxCnt) begin
            set_err    = 1'b1;
            state_next = ST_DONE;
          end else begin
            state_next = ST_WRITE;
          end
        end else if (timeout) begin
          set_err    = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_WRITE:   state_next = ST_COLLECT;
      default:    state_next = ST_DONE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      idle_cnt   <= '0;
      word_cnt_o <= '0;
      err_o      <= 1'b0;
    end else begin
      state <= state_next;
      if (set_err) err_o <= 1'b1;
      if (state == ST_WRITE) word_cnt_o <= word_cnt_o + 1'b1;
      if (rx_dv_i || timeout) idle_cnt <= '0;
      else if (idle_tick)     idle_cnt <= idle_cnt + 1'b1;
    end
  end

  // Port owner mux: the controller drives writes, DONE passes fetch through.
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = word;
    mem_wmask_o = 4'h0;
    fetch_gnt_o = 1'b0;
    case (state)
      ST_WRITE: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = word_cnt_o[AddrW-1:0];
        mem_wmask_o = 4'hF;
      end
      ST_DONE: begin
        mem_req_o   = fetch_req_i;
        mem_addr_o  = fetch_addr_i;
        fetch_gnt_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign core_rst_hold_o = (state != ST_DONE);
  assign done_o          = (state == ST_DONE);
  assign state_o         = state;

endmodule

// File: tb/tb_iccm_prog_ctrl.sv
// Self-checking bench for iccm_prog_ctrl: directed test-plan cases plus
// randomized programming sessions scored against a word-level reference model.
module tb_iccm_prog_ctrl;

  localparam int          AW    = 12;
  localparam int          DW    = 32;
  localparam int          MAXW  = 2;
  localparam int          TMO   = 16;
  localparam logic [31:0] ENDW  = 32'h0000_0FFF;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          prog_en = 1'b0;
  logic          rx_dv = 1'b0;
  logic [7:0]    rx_byte = 8'h00;
  logic          fetch_req = 1'b0;
  logic [AW-1:0] fetch_addr = '0;
  logic          fetch_gnt, mem_req, mem_we, core_rst_hold, done, err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_wmask;
  logic [AW:0]   word_cnt;
  logic [1:0]    dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  logic [AW+DW-1:0] exp_q[$];
  logic [7:0]       tx_q[$];
  int               gap_q[$];
  int               exp_cnt;
  logic             exp_err;
  logic             prog_phase = 1'b0;

  iccm_prog_ctrl #(
    .AddrW(AW), .DataW(DW), .MaxWords(MAXW), .EndWord(ENDW), .TimeoutCycles(TMO)
  ) dut (
    .clk_i(clk), .rst_i(rst), .prog_en_i(prog_en), .rx_dv_i(rx_dv),
    .rx_byte_i(rx_byte), .fetch_req_i(fetch_req), .fetch_addr_i(fetch_addr),
    .fetch_gnt_o(fetch_gnt), .mem_req_o(mem_req), .mem_we_o(mem_we),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_wmask_o(mem_wmask),
    .core_rst_hold_o(core_rst_hold), .done_o(done), .err_o(err),
    .word_cnt_o(word_cnt), .state_o(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: every ICCM write must match the head of the expected queue
  always @(negedge clk) begin
    if (!rst && mem_req && mem_we) begin
      check("write_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        check("write_addr_data", {mem_addr, mem_wdata}, exp_q.pop_front());
        check("write_mask", mem_wmask, 4'hF);
      end
    end
    if (!rst && prog_phase) begin
      check("gnt_during_prog", fetch_gnt, 1'b0);
      check("req_only_writes", mem_req & ~mem_we, 1'b0);
    end
  end

  task automatic do_reset(input logic pe);
    rst = 1'b1; prog_en = pe; rx_dv = 1'b0; fetch_req = 1'b0; prog_phase = 1'b0;
    exp_q.delete();
    tick(); tick();
    check("rst_hold", core_rst_hold, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_word_cnt", word_cnt, 0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_gnt", fetch_gnt, 1'b0);
    check("rst_state", dbg_state, 2'd0);
    rst = 1'b0;
    if (pe) begin
      tick(); tick();
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_dv = 1'b1; rx_byte = b;
    tick();
    rx_dv = 1'b0; rx_byte = $urandom_range(255);
    repeat (gap) tick();
  endtask

  task automatic push_word(input logic [31:0] w, input int max_gap);
    for (int k = 0; k < 4; k++) begin
      tx_q.push_back(w[8*k +: 8]);
      gap_q.push_back($urandom_range(max_gap));
    end
  endtask

  // Reference model: whole words in order; terminator ends, overflow errors.
  task automatic model_session(output int end_idx);
    logic [31:0] w;
    int cnt;
    cnt = 0; exp_err = 1'b0; end_idx = -1;
    for (int i = 0; i + 3 < tx_q.size(); i += 4) begin
      w = {tx_q[i+3], tx_q[i+2], tx_q[i+1], tx_q[i]};
      if (w == ENDW) begin
        end_idx = i + 3;
        break;
      end
      if (cnt == MAXW) begin
        exp_err = 1'b1;
        end_idx = i + 3;
        break;
      end
      exp_q.push_back({AW'(cnt), w});
      cnt++;
    end
    exp_cnt = cnt;
  endtask

  task automatic run_session(input string name);
    int end_idx;
    int waited;
    model_session(end_idx);
    prog_phase = 1'b1;
    fetch_req = 1'b1; fetch_addr = AW'($urandom_range(4095));
    for (int i = 0; i < tx_q.size(); i++) begin
      if (i == end_idx) prog_phase = 1'b0;
      send_byte(tx_q[i], gap_q[i]);
    end
    prog_phase = 1'b0;
    waited = 0;
    while (!done && waited < 20) begin
      tick();
      waited++;
    end
    check({name, "_done"}, done, 1'b1);
    check({name, "_hold"}, core_rst_hold, 1'b0);
    check({name, "_err"}, err, exp_err);
    check({name, "_word_cnt"}, word_cnt, exp_cnt);
    check({name, "_missing_writes"}, exp_q.size(), 0);
    for (int k = 0; k < 3; k++) begin
      fetch_req = $urandom_range(1); fetch_addr = AW'($urandom_range(4095));
      #1;
      check({name, "_fetch_req"}, mem_req, fetch_req);
      check({name, "_fetch_addr"}, mem_addr, fetch_addr);
      check({name, "_fetch_we"}, mem_we, 1'b0);
      check({name, "_fetch_mask"}, mem_wmask, 4'h0);
      check({name, "_fetch_gnt"}, fetch_gnt, 1'b1);
      tick();
    end
    fetch_req = 1'b0;
    tx_q.delete(); gap_q.delete();
  endtask

  initial begin
    // basic program: two words then terminator
    do_reset(1'b1);
    push_word(32'h0000_0513, 1); push_word(32'h0010_0593, 1); push_word(ENDW, 1);
    run_session("basic");

    // bypass: DONE on the second cycle, fetch pass-through, rx ignored
    rst = 1'b1; prog_en = 1'b0; tick(); tick();
    rst = 1'b0;
    #1 check("bypass_idle_done", done, 1'b0);
    tick();
    check("bypass_done", done, 1'b1);
    check("bypass_hold", core_rst_hold, 1'b0);
    fetch_req = 1'b1; fetch_addr = 12'h004;
    #1;
    check("bypass_req", mem_req, 1'b1);
    check("bypass_addr", mem_addr, 12'h004);
    check("bypass_we", mem_we, 1'b0);
    check("bypass_gnt", fetch_gnt, 1'b1);
    fetch_req = 1'b0;
    for (int k = 0; k < 4; k++) send_byte(8'h5A, 0);
    check("bypass_word_cnt", word_cnt, 0);

    // byte arriving during the WRITE cycle starts the next word
    do_reset(1'b1);
    push_word(32'h1234_5678, 0); push_word(32'hDDCC_BBAA, 0); push_word(ENDW, 0);
    run_session("write_cycle_byte");

    // timeout mid-word after one good word
    do_reset(1'b1);
    exp_q.push_back({AW'(0), 32'hCAFE_0001});
    for (int k = 0; k < 4; k++) send_byte(8'(32'hCAFE_0001 >> (8*k)), 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0);
    repeat (TMO - 2) tick();
    check("tmo_not_yet", done, 1'b0);
    repeat (3) tick();
    check("tmo_done", done, 1'b1);
    check("tmo_err", err, 1'b1);
    check("tmo_word_cnt", word_cnt, 1);
    check("tmo_missing_writes", exp_q.size(), 0);

    // overflow: three words with room for two
    do_reset(1'b1);
    push_word(32'hA000_0001, 2); push_word(32'hA000_0002, 2); push_word(32'hA000_0003, 2);
    run_session("overflow");

    // reset mid-word, then a fresh word lands at address 0
    do_reset(1'b1);
    send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0);
    rst = 1'b1;
    tick();
    check("midrst_state", dbg_state, 2'd0);
    check("midrst_hold", core_rst_hold, 1'b1);
    rst = 1'b0;
    tick(); tick();
    push_word(32'h4433_2211, 1); push_word(ENDW, 1);
    run_session("midrst");

    // randomized sessions
    for (int s = 0; s < 12; s++) begin
      int nw;
      do_reset(1'b1);
      nw = $urandom_range(3);
      for (int w = 0; w < nw; w++) push_word($urandom, 3);
      push_word(ENDW, 3);
      for (int j = 0; j < int'($urandom_range(3)); j++) begin
        tx_q.push_back(8'($urandom_range(255)));
        gap_q.push_back(0);
      end
      run_session($sformatf("rand%0d", s));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/iccm_prog_ctrl.md
Name: iccm_prog_ctrl

Overview:
- Boot-time programming controller for the instruction memory (ICCM).
- Collects UART-received bytes into 32-bit little-endian words and writes them sequentially from word address 0.
- Owns the ICCM single port while programming and holds the core in reset; afterwards it hands the port to the instruction-fetch SRAM adapter.
- Sits between the UART byte receiver, the TL-UL SRAM adapter request side, the instruction memory and the reset manager.

Parameters:
- AddrW, 12, ICCM word-address width.
- DataW, 32, ICCM data width; fixed at 4 bytes per word.
- MaxWords, 4096, number of writable words; must be ≤ 2**AddrW.
- EndWord, 32'h0000_0FFF, terminator word; ends programming and is not written.
- TimeoutCycles, 1_000_000, idle cycles allowed mid-word before an error is flagged.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- prog_en_i  in  1  programming strap; sampled only in IDLE
- rx_dv_i  in  1  single-cycle strobe: rx_byte_i is valid
- rx_byte_i  in  8  received byte
- fetch_req_i  in  1  read request from the fetch SRAM adapter
- fetch_addr_i  in  AddrW  fetch word address
- fetch_gnt_o  out  1  grant to the fetch adapter
- mem_req_o  out  1  ICCM request
- mem_we_o  out  1  ICCM write enable
- mem_addr_o  out  AddrW  ICCM word address
- mem_wdata_o  out  DataW  ICCM write data
- mem_wmask_o  out  4  ICCM byte mask; 4'hF on writes, 4'h0 otherwise
- core_rst_hold_o  out  1  to reset manager; 1 keeps the core in reset
- done_o  out  1  programming finished (or bypassed)
- err_o  out  1  sticky error (timeout or overflow)
- word_cnt_o  out  AddrW+1  number of words written

Behaviour:
- Reset values: state IDLE, byte_cnt 0, word_cnt_o 0, idle counter 0, core_rst_hold_o 1, done_o 0, err_o 0, mem_req_o 0, mem_we_o 0, fetch_gnt_o 0.
- States: IDLE, COLLECT, WRITE, DONE. core_rst_hold_o = (state != DONE). done_o = (state == DONE).
- IDLE: prog_en_i=1 → COLLECT next cycle. prog_en_i=0 → DONE next cycle (bypass).
- COLLECT, on each rx_dv_i:
  - Shift rx_byte_i into word[8*byte_cnt +: 8], byte_cnt++, clear idle counter.
  - On the 4th byte, with the assembled word available combinationally:
    - word == EndWord → DONE; no write.
    - else word_cnt_o == MaxWords → err_o=1, DONE; no write.
    - else → WRITE; byte_cnt wraps to 0.
- Timeout:
  - The idle counter increments only in COLLECT with byte_cnt≠0 and no rx_dv_i.
  - On reaching TimeoutCycles: err_o=1, DONE; the partial word is discarded.
  - With byte_cnt=0 the controller waits indefinitely.
- WRITE (exactly 1 cycle):
  - mem_req_o=1, mem_we_o=1, mem_addr_o=word_cnt_o[AddrW-1:0], mem_wdata_o=word, mem_wmask_o=4'hF.
  - word_cnt_o increments at the end of the cycle. Next state COLLECT.
  - An rx_dv_i arriving in WRITE is captured as byte 0 of the next word (byte_cnt becomes 1). No byte is ever dropped.
- Write latency: last byte strobe in cycle N → ICCM write in cycle N+1.
- Arbitration:
  - In IDLE/COLLECT/WRITE: fetch_gnt_o=0 and fetch requests are ignored.
  - In DONE: mem_req_o=fetch_req_i, mem_addr_o=fetch_addr_i, mem_we_o=0, mem_wmask_o=0, fetch_gnt_o=1 (combinational pass-through, zero latency).
  - rvalid/rdata go directly from memory to the adapter, not through this block.
- DONE is terminal. rx_dv_i is ignored and err_o/word_cnt_o hold until rst_i.
- rst_i asserted mid-word or mid-write: all state returns to reset values in the next cycle. A write in progress in that cycle still completes; the ICCM is not cleared.
- err_o does not block the hand-over: the core is released even on error, and firmware or debug inspects err_o.

Decomposition:
- Shared package iccm_prog_pkg:
  - state enum prog_state_e {IDLE, COLLECT, WRITE, DONE}
  - default EndWord constant
  - BytesPerWord=4 localparam
- One natural sub-module, iccm_word_packer:
  - byte_cnt, word register, last-byte flag.
  - Inputs: clk_i, rst_i, clr, byte strobe, byte.
- FSM, idle counter and output mux stay in the top module.

Test Plan:
- prog_en_i=1; send bytes 13 05 00 00, 93 05 10 00, FF 0F 00 00 → writes 32'h0000_0513 @0 and 32'h0010_0593 @1. Then DONE, word_cnt_o=2, core_rst_hold_o falls, err_o=0, no write of the terminator.
- prog_en_i=0 after reset → DONE on the 2nd cycle. fetch_req_i=1 with addr 12'h004 → mem_req_o=1, mem_addr_o=4, mem_we_o=0, fetch_gnt_o=1 in the same cycle.
- rx_dv_i asserted in the WRITE cycle with byte AA → next word's byte 0 = 8'hAA. Completing it with BB CC DD → write 32'hDDCC_BBAA @1.
- Send 2 bytes, then idle TimeoutCycles (use param=16) → err_o=1, DONE, no write, word_cnt_o unchanged.
- MaxWords=2; send 3 non-terminator words → 2 writes, then err_o=1 and DONE on the 3rd word's last byte, with no 3rd write.
- Assert rst_i after 3 bytes → next cycle IDLE, byte_cnt=0, core_rst_hold_o=1. A fresh 4-byte word then writes @0.
